// File: rtl/lgate_truth_scanner.sv
// rtl/lgate_truth_scanner.sv - drives {a,b}=00..11 into the gate block and captures a 4-entry truth table
// Optional self-check is compiled in when LGATE_SCAN_CHECK_EN is defined (adds mismatch[3:0] and pass ports).
module lgate_truth_scanner #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         a_out,
   output logic         b_out,
   input  logic [6:0]   y_in,
   input  logic [1:0]   rd_idx,
   output logic [6:0]   rd_data,
   output logic         busy,
   output logic         done,
   output logic         table_valid
`ifdef LGATE_SCAN_CHECK_EN
   ,
   output logic [3:0]   mismatch,
   output logic         pass
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CAPT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Last settle count before the capture cycle; the vector is held one extra cycle in CAPT.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        idx;
   logic [6:0]        tbl [4];

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded status outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            busy = 1'b1;
            if (cnt == CNT_LAST) begin
               state_nxt = CAPT;
            end
         end
         CAPT: begin
            busy      = 1'b1;
            state_nxt = (idx == 2'd3) ? DONE : SETTLE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Vector drive, settle counting and table capture
   always_ff @(posedge clk) begin
      if (rst) begin
         idx         <= 2'd0;
         cnt         <= '0;
         a_out       <= 1'b0;
         b_out       <= 1'b0;
         table_valid <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            tbl[i] <= 7'h00;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx            <= 2'd0;
                  cnt            <= '0;
                  {a_out, b_out} <= 2'b00;
                  table_valid    <= 1'b0;
               end
            end
            SETTLE: begin
               cnt <= cnt + CNT_W'(1);
            end
            CAPT: begin
               tbl[idx] <= y_in;
               // The last vector stays on the gate inputs until the next scan starts.
               if (idx != 2'd3) begin
                  idx            <= idx + 2'd1;
                  {a_out, b_out} <= idx + 2'd1;
                  cnt            <= '0;
               end
            end
            DONE: begin
               table_valid <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Table read port is combinational so the display can scan it at any time
   always_comb begin
      rd_data = tbl[rd_idx];
   end

`ifdef LGATE_SCAN_CHECK_EN
   logic [6:0] y_exp;

   // Reference truth of the gate block for the vector currently driven
   always_comb begin
      y_exp = {~a_out, ~(a_out ^ b_out), ~(a_out | b_out), ~(a_out & b_out),
               a_out | b_out, a_out ^ b_out, a_out & b_out};
   end

   // Per-vector mismatch flags and the scan verdict
   always_ff @(posedge clk) begin
      if (rst) begin
         mismatch <= 4'b0000;
         pass     <= 1'b0;
      end else if (state == IDLE && start) begin
         mismatch <= 4'b0000;
         pass     <= 1'b0;
      end else if (state == CAPT) begin
         if (y_in != y_exp) begin
            mismatch[idx] <= 1'b1;
         end
      end else if (state == DONE) begin
         // The final capture's flag is already registered by the time DONE is reached.
         pass <= (mismatch == 4'b0000);
      end
   end
`endif

endmodule

// File: tb/tb_lgate_truth_scanner.sv
// tb/tb_lgate_truth_scanner.sv - randomized self-checking bench for lgate_truth_scanner (LGATE_SCAN_CHECK_EN optional)
module tb_lgate_truth_scanner;

   localparam int S = 2;
   localparam int P = S + 1;
   localparam int L = 4 * P;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       a_out, b_out, busy, done, table_valid;
   logic [6:0] y_in, rd_data;
   logic [1:0] rd_idx = 2'd0;
`ifdef LGATE_SCAN_CHECK_EN
   logic [3:0] mismatch;
   logic       pass;
`endif

   logic [6:0] fault [4];

   // model state: ph = 0 idle, 1..L scan cycle number, L+1 done cycle
   int         ph;
   logic [1:0] m_ab;
   logic [6:0] m_tbl [4];
   logic       m_tv;
   logic [3:0] m_mis;
   logic       m_pass;

   int n_cmp = 0;
   int n_err = 0;
   int n_done = 0;

   lgate_truth_scanner #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a_out       (a_out),
      .b_out       (b_out),
      .y_in        (y_in),
      .rd_idx      (rd_idx),
      .rd_data     (rd_data),
      .busy        (busy),
      .done        (done),
      .table_valid (table_valid)
`ifdef LGATE_SCAN_CHECK_EN
      ,
      .mismatch    (mismatch),
      .pass        (pass)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] gate_ref(input logic a, input logic b);
      return {~a, ~(a ^ b), ~(a | b), ~(a & b), a | b, a ^ b, a & b};
   endfunction

   // gate block model with an injectable per-vector error mask
   always_comb y_in = gate_ref(a_out, b_out) ^ fault[{a_out, b_out}];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic st, input logic rs);
      logic [1:0] v;
      if (rs) begin
         ph = 0; m_ab = 2'b00; m_tv = 1'b0; m_mis = 4'b0; m_pass = 1'b0;
         for (int i = 0; i < 4; i++) m_tbl[i] = 7'h00;
      end else if (ph == 0) begin
         if (st) begin
            ph = 1; m_ab = 2'b00; m_tv = 1'b0; m_mis = 4'b0; m_pass = 1'b0;
         end
      end else if (ph <= L) begin
         if (ph % P == 0) begin
            v = 2'((ph - 1) / P);
            m_tbl[v] = gate_ref(v[1], v[0]) ^ fault[v];
            if (fault[v] != 7'h00) m_mis[v] = 1'b1;
         end
         ph++;
         if (ph <= L) m_ab = 2'((ph - 1) / P);
      end else begin
         ph = 0; m_tv = 1'b1; m_pass = (m_mis == 4'b0);
      end
   endtask

   task automatic compare_all();
      check_eq("busy", busy, (ph >= 1 && ph <= L));
      check_eq("done", done, (ph == L + 1));
      check_eq("ab", {a_out, b_out}, m_ab);
      check_eq("table_valid", table_valid, m_tv);
      check_eq("rd_data", rd_data, m_tbl[rd_idx]);
`ifdef LGATE_SCAN_CHECK_EN
      check_eq("mismatch", mismatch, m_mis);
      check_eq("pass", pass, m_pass);
`endif
   endtask

   task automatic cycle(input logic st, input logic rs);
      @(negedge clk);
      start  = st;
      rst    = rs;
      rd_idx = 2'($urandom_range(0, 3));
      @(posedge clk);
      model_edge(st, rs);
      #1;
      if (done) n_done++;
      compare_all();
   endtask

   task automatic read_all(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rd_idx = 2'(i);
         #1 check_eq(tag, rd_data, e[i]);
      end
   endtask

   initial begin
      int first_done;
      int d0;
      logic [6:0] m;
      for (int i = 0; i < 4; i++) fault[i] = 7'h00;
      ph = 0; m_ab = 2'b00; m_tv = 1'b0; m_mis = 4'b0; m_pass = 1'b0;
      for (int i = 0; i < 4; i++) m_tbl[i] = 7'h00;

      // reset state
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);

      // single scan: latency, vector sequence (via model) and table contents
      cycle(1'b1, 1'b0);
      first_done = -1;
      for (int k = 1; k <= 16; k++) begin
         cycle(1'b0, 1'b0);
         if (done && first_done < 0) first_done = k;
      end
      check_eq("done_latency", first_done, 12);
      read_all("table_consts", 7'h78, 7'h4E, 7'h0E, 7'h25);
      check_eq("ab_hold", {a_out, b_out}, 2'b11);

      // second start 5 cycles into a scan is ignored
      n_done = 0;
      cycle(1'b1, 1'b0);
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      for (int k = 0; k < 16; k++) cycle(1'b0, 1'b0);
      check_eq("single_done", n_done, 1);

      // start held high: back-to-back scans
      n_done = 0;
      first_done = -1;
      d0 = -1;
      for (int k = 0; k < 30; k++) begin
         cycle(1'b1, 1'b0);
         if (done) begin
            if (first_done < 0) first_done = k; else d0 = k;
         end
      end
      check_eq("held_done_cnt", n_done, 2);
      check_eq("held_done1", first_done, 12);
      check_eq("held_done2", d0, 26);
      for (int k = 0; k < 16; k++) cycle(1'b0, 1'b0);

      // reset mid-scan clears everything including the table
      cycle(1'b1, 1'b0);
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_tv", table_valid, 1'b0);
      read_all("rst_table", 7'h00, 7'h00, 7'h00, 7'h00);

`ifdef LGATE_SCAN_CHECK_EN
      // y[1] stuck at 0, then a clean scan
      for (int i = 0; i < 4; i++) begin
         m = gate_ref(i[1], i[0]);
         fault[i] = m & 7'h02;
      end
      cycle(1'b1, 1'b0);
      for (int k = 0; k < 14; k++) cycle(1'b0, 1'b0);
      check_eq("stuck_mismatch", mismatch, 4'b0110);
      check_eq("stuck_pass", pass, 1'b0);
      for (int i = 0; i < 4; i++) fault[i] = 7'h00;
      cycle(1'b1, 1'b0);
      for (int k = 0; k < 14; k++) cycle(1'b0, 1'b0);
      check_eq("clean_mismatch", mismatch, 4'b0000);
      check_eq("clean_pass", pass, 1'b1);
`endif

      // randomized traffic: start gaps, occasional reset, random gate faults
      for (int k = 0; k < 600; k++) begin
         if (ph == 0) begin
            for (int i = 0; i < 4; i++)
               fault[i] = ($urandom_range(0, 3) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'h00;
         end
         cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
